// File: rtl/valu_slot_scheduler_pkg.sv
// rvvLitePkg: shared types and helpers for the vector ALU slot scheduler.
//   vsched_entry_t : one buffered instruction (payload plus hazard metadata).
//   vslot_state_t  : per-slot busy flag and the register it will write.
//   rr_pick        : round-robin pick of the first request at or after a pointer.
// Fields are sized to the largest supported configuration. Narrower instances
// zero-extend into them and truncate on the way out.
package rvvLitePkg;

    localparam int VSCHED_PAYLOAD_MAX = 256;
    localparam int VSCHED_REG_MAX     = 8;
    localparam int VSCHED_SLOT_MAX    = 4;

    typedef struct packed {
        logic [VSCHED_PAYLOAD_MAX-1:0] payload;
        logic [VSCHED_REG_MAX-1:0]     vd;
        logic [VSCHED_REG_MAX-1:0]     vs1;
        logic [VSCHED_REG_MAX-1:0]     vs2;
        logic                          uses_vs1;
        logic                          uses_vs2;
        logic                          is_store;
    } vsched_entry_t;

    typedef struct packed {
        logic                      busy;
        logic [VSCHED_REG_MAX-1:0] dst;
        logic                      wr;
    } vslot_state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_grant_t;

    // First set bit of req[n-1:0] scanning upward from ptr and wrapping at n.
    function automatic rr_grant_t rr_pick(input logic [VSCHED_SLOT_MAX-1:0] req,
                                          input logic [1:0] ptr,
                                          input int n);
        rr_grant_t g;
        int        k;
        g = '0;
        for (int off = 0; off < VSCHED_SLOT_MAX; off++) begin
            k = (int'(ptr) + off) % n;
            if (off < n && !g.found && req[k]) begin
                g.found = 1'b1;
                g.idx   = 2'(k);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/valu_slot_scheduler_fifo.sv
// vSchedFifo: synchronous in-order FIFO of vsched_entry_t.
//   clk, rst      : clock, synchronous active-low reset (pointers and count only)
//   push, din     : write an entry (ignored while full)
//   pop           : drop the head (ignored while empty)
//   head          : current oldest entry, valid when !empty
//   full, empty   : occupancy flags
//   count         : number of stored entries
module vSchedFifo
    import rvvLitePkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  vsched_entry_t            din,
    input  logic                     pop,
    output vsched_entry_t            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    vsched_entry_t mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

endmodule

// File: rtl/valu_slot_scheduler.sv
// valu_slot_scheduler: in-order issue of decoded vector instructions to ALU slots.
//   clk, rst                 : clock, synchronous active-low reset
//   in_valid/in_ready        : decode handshake, in_payload + register metadata
//   stall                    : global stall, suppresses issue and freezes arbitration
//   slot_active              : per-slot active, used to retire busy slots
//   slot_internal_active     : per-slot request for the shared register read path
//   slot_init, slot_payload  : registered one-hot issue pulse and its payload
//   slot_block               : combinational read-path block per slot
//   idle                     : FIFO empty and no slot busy
module valu_slot_scheduler
    import rvvLitePkg::*;
#(
    parameter int SLOT_COUNT = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int PAYLOAD_W  = 256,
    parameter int REG_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    input  logic [REG_W-1:0]      in_vd,
    input  logic [REG_W-1:0]      in_vs1,
    input  logic [REG_W-1:0]      in_vs2,
    input  logic                  in_uses_vs1,
    input  logic                  in_uses_vs2,
    input  logic                  in_is_store,
    input  logic                  stall,
    input  logic [SLOT_COUNT-1:0] slot_active,
    input  logic [SLOT_COUNT-1:0] slot_internal_active,
    output logic [SLOT_COUNT-1:0] slot_init,
    output logic [PAYLOAD_W-1:0]  slot_payload,
    output logic [SLOT_COUNT-1:0] slot_block,
    output logic                  idle
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    vsched_entry_t         in_entry;
    vsched_entry_t         head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  push;
    logic                  issue;
    logic                  hazard;
    logic                  any_free;
    logic [SLOT_COUNT-1:0] busy_vec;
    logic [SLOT_COUNT-1:0] init_next;
    vslot_state_t          slot_state [SLOT_COUNT];
    logic [1:0]            rr;
    rr_grant_t             grant;

    always_comb begin
        in_entry          = '0;
        in_entry.payload  = VSCHED_PAYLOAD_MAX'(in_payload);
        in_entry.vd       = VSCHED_REG_MAX'(in_vd);
        in_entry.vs1      = VSCHED_REG_MAX'(in_vs1);
        in_entry.vs2      = VSCHED_REG_MAX'(in_vs2);
        in_entry.uses_vs1 = in_uses_vs1;
        in_entry.uses_vs2 = in_uses_vs2;
        in_entry.is_store = in_is_store;
    end

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;

    vSchedFifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_entry),
        .pop   (issue),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Hazard check of the head against every in-flight writer, plus the
    // lowest-index free slot. For a store, the vd compare guards the store data.
    always_comb begin
        hazard    = 1'b0;
        busy_vec  = '0;
        init_next = '0;
        any_free  = 1'b0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            busy_vec[i] = slot_state[i].busy;
            if (slot_state[i].busy && slot_state[i].wr &&
                ((head.uses_vs1 && slot_state[i].dst == head.vs1) ||
                 (head.uses_vs2 && slot_state[i].dst == head.vs2) ||
                 (slot_state[i].dst == head.vd)))
                hazard = 1'b1;
            if (!slot_state[i].busy && !any_free) begin
                any_free     = 1'b1;
                init_next[i] = 1'b1;
            end
        end
    end

    assign issue = !fifo_empty && !stall && any_free && !hazard;
    assign idle  = (fifo_count == '0) && !(|busy_vec);

    // Read-path arbitration: the granted requester proceeds, the others are blocked.
    always_comb begin
        grant      = rr_pick(VSCHED_SLOT_MAX'(slot_internal_active), rr, SLOT_COUNT);
        slot_block = '0;
        for (int i = 0; i < SLOT_COUNT; i++)
            slot_block[i] = slot_internal_active[i] && !(grant.found && grant.idx == 2'(i));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_init    <= '0;
            slot_payload <= '0;
            rr           <= '0;
            for (int i = 0; i < SLOT_COUNT; i++)
                slot_state[i] <= '0;
        end else begin
            slot_init <= issue ? init_next : '0;
            if (issue)
                slot_payload <= head.payload[PAYLOAD_W-1:0];
            // A slot whose init pulse is still out has not had a chance to raise
            // active yet, so it must not be retired in that cycle.
            for (int i = 0; i < SLOT_COUNT; i++) begin
                if (issue && init_next[i]) begin
                    slot_state[i].busy <= 1'b1;
                    slot_state[i].dst  <= head.vd;
                    slot_state[i].wr   <= !head.is_store;
                end else if (slot_state[i].busy && !slot_active[i] && !slot_init[i]) begin
                    slot_state[i].busy <= 1'b0;
                end
            end
            if (grant.found && !stall)
                rr <= 2'((int'(grant.idx) + 1) % SLOT_COUNT);
        end
    end

endmodule
